filtr_feeder: RTL

FILTR_FEEDER -- requirements
Module: filtr_feeder

---
 rtl/filtr_pkg.sv | 22 ++
 rtl/filtr_feeder_fifo.sv | 51 +++++
 rtl/filtr_feeder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/filtr_pkg.sv
// Shared constants and FSM encoding for the filter-project feeder blocks.
package filtr_pkg;

   localparam int FILTR_DATA_SIZE      = 5;
   localparam int FILTR_FIFO_DEPTH     = 4;
   localparam int FILTR_GAP_CYCLES     = 5;
   localparam int FILTR_TIMEOUT_CYCLES = 64;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      CAPTURE   = 3'd3,
      GAP       = 3'd4
   } feed_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/filtr_feeder_fifo.sv
// Input sample buffer: power-of-two ring with wrap-around pointers and a count register.
module filtr_feeder_fifo
   import filtr_pkg::*;
#(
   parameter int DATA_SIZE  = FILTR_DATA_SIZE,
   parameter int FIFO_DEPTH = FILTR_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] head,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = cnt_w(FIFO_DEPTH);

   logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic                 do_push;
   logic                 do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/filtr_feeder.sv
// Feeds buffered samples one at a time into a filter and returns each result downstream.
// Optional WAIT_DONE watchdog with sticky err: define FILTR_FEEDER_TIMEOUT_EN.
module filtr_feeder
   import filtr_pkg::*;
#(
   parameter int DATA_SIZE      = FILTR_DATA_SIZE,
   parameter int FIFO_DEPTH     = FILTR_FIFO_DEPTH,
   parameter int GAP_CYCLES     = FILTR_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = FILTR_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATA_SIZE-1:0] f_data_in,
   output logic                 f_sample,
   input  logic [DATA_SIZE-1:0] f_data_out,
   input  logic                 f_filter_done,
   output logic [DATA_SIZE-1:0] res_data,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 busy,
   output logic                 err
);

   localparam int GW = cnt_w(GAP_CYCLES);

   feed_state_t          state;
   feed_state_t          state_nxt;
   logic                 rst_done;
   logic                 done_q;
   logic                 done_rise;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic [DATA_SIZE-1:0] head;
   logic [GW-1:0]        gap_cnt;
   logic                 gap_end;
   logic                 timeout;

   // in_ready stays low through reset and comes up on the first edge after release.
   assign in_ready  = rst_done && !fifo_full;
   assign pop       = (state == IDLE) && !fifo_empty;
   assign done_rise = f_filter_done && !done_q;
   assign gap_end   = (gap_cnt == GW'(GAP_CYCLES - 1));

   filtr_feeder_fifo #(
      .DATA_SIZE  (DATA_SIZE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid && in_ready),
      .push_data (in_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef FILTR_FEEDER_TIMEOUT_EN
   localparam int TW = cnt_w(TIMEOUT_CYCLES);

   logic [TW-1:0] to_cnt;
   logic          err_q;

   // A done edge on the final cycle still wins over the timeout.
   assign timeout = (state == WAIT_DONE) && !done_rise && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;
         else                    to_cnt <= '0;
         if (timeout) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!fifo_empty) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (done_rise)    state_nxt = CAPTURE;
            else if (timeout) state_nxt = GAP;
         end
         CAPTURE:   if (res_ready) state_nxt = GAP;
         GAP:       if (gap_end) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      f_sample  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE:    busy      = 1'b0;
         ISSUE:   f_sample  = 1'b1;
         CAPTURE: res_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_done  <= 1'b0;
         done_q    <= 1'b0;
         f_data_in <= '0;
         res_data  <= '0;
         gap_cnt   <= '0;
      end else begin
         rst_done <= 1'b1;
         done_q   <= f_filter_done;
         if (pop) f_data_in <= head;
         if ((state == WAIT_DONE) && done_rise) res_data <= f_data_out;
         if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
         else              gap_cnt <= '0;
      end
   end

endmodule
